// File: rtl/digital_tube_driver_if.sv
// rtl/digital_tube_driver_if.sv - MMIO register bus between the CPU and the digital tube driver
// The CPU side is the master; the driver is the slave and owns oReadData.
interface digital_tube_driver_if;
   logic        iWriteEnable;
   logic        iReadEnable;
   logic [1:0]  iAddress;
   logic [31:0] iWriteData;
   logic [31:0] oReadData;

   modport master (
      output iWriteEnable,
      output iReadEnable,
      output iAddress,
      output iWriteData,
      input  oReadData
   );

   modport slave (
      input  iWriteEnable,
      input  iReadEnable,
      input  iAddress,
      input  iWriteData,
      output oReadData
   );
endinterface

// File: rtl/digital_tube_driver.sv
// rtl/digital_tube_driver.sv - eight-digit seven-segment scanner with MMIO VALUE/DIGIT_EN/DP_MASK registers
// Optional leading-zero suppression: define DIGITAL_TUBE_LEADING_ZERO_BLANK_EN.
module digital_tube_driver #(
   parameter int SCAN_PERIOD_CYCLES = 50000
) (
   input  logic                       iFpgaClk,
   input  logic                       iFpgaRst,
   digital_tube_driver_if.slave       bus,
   output logic [7:0]                 oDigitalTubeNotEnable,
   output logic [7:0]                 oDigitalTubeShape
);

   localparam int              LP_CW       = (SCAN_PERIOD_CYCLES > 2) ? $clog2(SCAN_PERIOD_CYCLES) : 1;
   localparam logic [LP_CW-1:0] LP_CNT_LAST = LP_CW'(SCAN_PERIOD_CYCLES - 1);

   logic [31:0]      r_value;
   logic [7:0]       r_digit_en;
   logic [7:0]       r_dp_mask;
   logic [LP_CW-1:0] r_cnt;
   logic [2:0]       r_idx;
   logic [31:0]      r_read_data;
   logic [7:0]       r_not_enable;
   logic [7:0]       r_shape;

   logic [3:0]       w_nibble;
   logic             w_lz_blank;
   logic [7:0]       w_not_enable_next;
   logic [7:0]       w_shape_next;
   logic [31:0]      w_read_mux;

   function automatic logic [6:0] decode_hex(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   assign w_nibble = r_value[{r_idx, 2'b00} +: 4];

`ifdef DIGITAL_TUBE_LEADING_ZERO_BLANK_EN
   // Blank when this nibble and everything above it is zero; digit 0 always shows.
   assign w_lz_blank = (r_idx != 3'd0) && ((r_value >> {r_idx, 2'b00}) == 32'd0);
`else
   assign w_lz_blank = 1'b0;
`endif

   always_comb begin
      w_not_enable_next = 8'hFF;
      w_shape_next      = 8'hFF;
      if ((r_cnt != '0) && r_digit_en[r_idx]) begin
         w_not_enable_next = ~(8'b1 << r_idx);
         w_shape_next      = {~r_dp_mask[r_idx], w_lz_blank ? 7'h7F : decode_hex(w_nibble)};
      end
   end

   always_comb begin
      w_read_mux = 32'd0;
      case (bus.iAddress)
         2'd0:    w_read_mux = r_value;
         2'd1:    w_read_mux = {24'd0, r_digit_en};
         2'd2:    w_read_mux = {24'd0, r_dp_mask};
         default: w_read_mux = 32'd0;
      endcase
   end

   always_ff @(posedge iFpgaClk or posedge iFpgaRst) begin
      if (iFpgaRst) begin
         r_value    <= 32'd0;
         r_digit_en <= 8'hFF;
         r_dp_mask  <= 8'h00;
      end else if (bus.iWriteEnable) begin
         case (bus.iAddress)
            2'd0:    r_value    <= bus.iWriteData;
            2'd1:    r_digit_en <= bus.iWriteData[7:0];
            2'd2:    r_dp_mask  <= bus.iWriteData[7:0];
            default: ;
         endcase
      end
   end

   // Read mux sees pre-write register values, so a same-cycle write/read returns old data.
   always_ff @(posedge iFpgaClk or posedge iFpgaRst) begin
      if (iFpgaRst) begin
         r_read_data <= 32'd0;
      end else if (bus.iReadEnable) begin
         r_read_data <= w_read_mux;
      end
   end

   always_ff @(posedge iFpgaClk or posedge iFpgaRst) begin
      if (iFpgaRst) begin
         r_cnt <= '0;
         r_idx <= 3'd0;
      end else if (r_cnt == LP_CNT_LAST) begin
         r_cnt <= '0;
         r_idx <= r_idx + 3'd1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge iFpgaClk or posedge iFpgaRst) begin
      if (iFpgaRst) begin
         r_not_enable <= 8'hFF;
         r_shape      <= 8'hFF;
      end else begin
         r_not_enable <= w_not_enable_next;
         r_shape      <= w_shape_next;
      end
   end

   assign oDigitalTubeNotEnable = r_not_enable;
   assign oDigitalTubeShape     = r_shape;
   assign bus.oReadData         = r_read_data;

endmodule

// File: tb/tb_digital_tube_driver.sv
// tb/tb_digital_tube_driver.sv - directed vector bench for digital_tube_driver at SCAN_PERIOD_CYCLES = 4
// Honors DIGITAL_TUBE_LEADING_ZERO_BLANK_EN when selecting expected glyphs.
module tb_digital_tube_driver;

   typedef struct {
      logic        we;
      logic        re;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
   } rb_vec_t;

   typedef struct {
      logic [7:0] ne;
      logic [7:0] sh;
   } slot_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] ne;
   logic [7:0] sh;
   int         checks = 0;
   int         errors = 0;
   int         ec = 0;

   rb_vec_t rb[12];
   slot_t   exp_frame[8];

   digital_tube_driver_if bus();

   digital_tube_driver #(.SCAN_PERIOD_CYCLES(4)) dut (
      .iFpgaClk              (clk),
      .iFpgaRst              (rst),
      .bus                   (bus),
      .oDigitalTubeNotEnable (ne),
      .oDigitalTubeShape     (sh)
   );

   always #5 clk = ~clk;

   localparam logic [63:0] NE_ALL   = 64'h7FBFDFEF_F7FBFDFE;
   localparam logic [63:0] NE_LOW4  = 64'hFFFFFFFF_F7FBFDFE;
   localparam logic [63:0] SH_89AB  = 64'h80908883_C6A1868E;
`ifdef DIGITAL_TUBE_LEADING_ZERO_BLANK_EN
   localparam logic [63:0] SH_ZERO  = 64'hFFFFFFFF_FFFFFFC0;
   localparam logic [63:0] SH_MASK  = 64'hFFFFFFFF_FFFFFF40;
   localparam logic [63:0] SH_0120  = 64'hFFFFFFFF_FFF9A4C0;
   localparam logic [63:0] SH_5000  = 64'hFFFFFFFF_92C0C0C0;
`else
   localparam logic [63:0] SH_ZERO  = 64'hC0C0C0C0_C0C0C0C0;
   localparam logic [63:0] SH_MASK  = 64'hFFFFFFFF_C0C0C040;
   localparam logic [63:0] SH_0120  = 64'hC0C0C0C0_C0F9A4C0;
   localparam logic [63:0] SH_5000  = 64'hC0C0C0C0_92C0C0C0;
`endif

   task automatic tick();
      @(posedge clk);
      #1;
      ec++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h", nm, act, exp);
      end
   endtask

   task automatic set_frame(input logic [63:0] nes, input logic [63:0] shs);
      for (int k = 0; k < 8; k++) begin
         exp_frame[k].ne = nes[8*k +: 8];
         exp_frame[k].sh = shs[8*k +: 8];
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.iAddress     = a;
      bus.iWriteData   = d;
      bus.iWriteEnable = 1'b1;
      tick();
      bus.iWriteEnable = 1'b0;
   endtask

   // Pins after edge ec show the scan state of cycle ec-1 counted from reset release.
   task automatic check_slot(input string nm);
      int t;
      int c;
      int k;
      logic [7:0] e_ne;
      logic [7:0] e_sh;
      t = ec - 1;
      c = t % 4;
      k = (t / 4) % 8;
      if (c == 0) begin
         e_ne = 8'hFF;
         e_sh = 8'hFF;
      end else begin
         e_ne = exp_frame[k].ne;
         e_sh = exp_frame[k].sh;
      end
      chk($sformatf("%s_t%0d", nm, t), {16'h0, ne, sh}, {16'h0, e_ne, e_sh});
   endtask

   task automatic frame_check(input string nm);
      while (ec % 32 != 0) tick();
      repeat (32) begin
         tick();
         check_slot(nm);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rb[0]  = '{1'b1, 1'b0, 2'd1, 32'hFFFF_FF5A, 32'h0000_0000};
      rb[1]  = '{1'b0, 1'b1, 2'd1, 32'h0,         32'h0000_005A};
      rb[2]  = '{1'b0, 1'b1, 2'd3, 32'h0,         32'h0000_0000};
      rb[3]  = '{1'b1, 1'b0, 2'd3, 32'hDEAD_BEEF, 32'h0000_0000};
      rb[4]  = '{1'b0, 1'b1, 2'd1, 32'h0,         32'h0000_005A};
      rb[5]  = '{1'b1, 1'b1, 2'd0, 32'h1234_5678, 32'h0000_0000};
      rb[6]  = '{1'b0, 1'b1, 2'd0, 32'h0,         32'h1234_5678};
      rb[7]  = '{1'b1, 1'b0, 2'd2, 32'h0000_01A5, 32'h1234_5678};
      rb[8]  = '{1'b0, 1'b0, 2'd0, 32'h0,         32'h1234_5678};
      rb[9]  = '{1'b0, 1'b1, 2'd2, 32'h0,         32'h0000_00A5};
      rb[10] = '{1'b0, 1'b1, 2'd3, 32'h0,         32'h0000_0000};
      rb[11] = '{1'b0, 1'b0, 2'd1, 32'h0,         32'h0000_0000};

      bus.iWriteEnable = 1'b0;
      bus.iReadEnable  = 1'b0;
      bus.iAddress     = 2'd0;
      bus.iWriteData   = 32'd0;

      #2 rst = 1'b1;
      repeat (3) tick();
      chk("rst_ne", {24'h0, ne}, 32'h0000_00FF);
      chk("rst_sh", {24'h0, sh}, 32'h0000_00FF);
      chk("rst_rd", bus.oReadData, 32'h0);

      rst = 1'b0;
      ec = 0;
      set_frame(NE_ALL, SH_ZERO);
      repeat (8) begin
         tick();
         check_slot("post_rst");
      end

      for (int i = 0; i < 12; i++) begin
         bus.iWriteEnable = rb[i].we;
         bus.iReadEnable  = rb[i].re;
         bus.iAddress     = rb[i].addr;
         bus.iWriteData   = rb[i].wdata;
         tick();
         chk($sformatf("rb%0d", i), bus.oReadData, rb[i].exp_rd);
      end
      bus.iWriteEnable = 1'b0;
      bus.iReadEnable  = 1'b0;

      wr(2'd0, 32'h89AB_CDEF);
      wr(2'd1, 32'h0000_00FF);
      wr(2'd2, 32'h0000_0000);
      set_frame(NE_ALL, SH_89AB);
      frame_check("frame");

      wr(2'd0, 32'h0000_0000);
      wr(2'd1, 32'h0000_000F);
      wr(2'd2, 32'h0000_0001);
      set_frame(NE_LOW4, SH_MASK);
      frame_check("mask");

      wr(2'd1, 32'h0000_00FF);
      wr(2'd2, 32'h0000_0000);
      wr(2'd0, 32'h0000_0120);
      set_frame(NE_ALL, SH_0120);
      frame_check("lz");

      wr(2'd0, 32'h89AB_CDEF);
      set_frame(NE_ALL, SH_89AB);
      while (ec % 32 != 14) tick();
      wr(2'd0, 32'h0000_5000);
      check_slot("scan_wr_old");
      set_frame(NE_ALL, SH_5000);
      repeat (3) begin
         tick();
         check_slot("scan_wr_new");
      end

      while (ec % 4 != 2) tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_pins", {16'h0, ne, sh}, 32'h0000_FFFF);
      chk("mid_rst_rd", bus.oReadData, 32'h0);
      repeat (2) tick();
      rst = 1'b0;
      ec = 0;
      set_frame(NE_ALL, SH_ZERO);
      repeat (6) begin
         tick();
         check_slot("mid_rst_rel");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
